// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and widths for the pipeline hazard controller
// Contents: FSM state encoding (3-bit, codes 4..7 unused), x0 register index,
// ecall wait-counter width.
package pipe_ctrl_pkg;

  localparam int ECALL_CNT_W = 16;
  localparam int STATE_W     = 3;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [STATE_W-1:0] {
    RUN        = 3'd0,
    LU_STALL   = 3'd1,
    ECALL_REQ  = 3'd2,
    ECALL_DONE = 3'd3
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// rtl/pipe_hazard_ctrl_hazard_cmp.sv - combinational load-use hazard detector
// Ports:
//   id_rs1/id_rs2         source registers of the instruction in ID
//   id_uses_rs1/rs2       ID instruction actually reads that source
//   ex_mem_read, ex_rd    EX instruction is a load, and its destination
//   load_use              ID needs a value the EX load has not produced yet
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline sequencer for load-use stalls, redirects and ecall I/O
// Ports:
//   clk, rst                     clock, async active-high reset
//   id_* / ex_*                  decode and execute stage hazard sources
//   io_ack                       I/O device finished servicing the ecall
//   stall, flush_if_id,
//   flush_id_ex, ecall_hold      combinational pipeline controls
//   io_req, io_timeout           registered I/O handshake outputs
//   state_dbg                    current FSM state
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned               LOAD_STALL_CYCLES = 1,
  parameter logic [ECALL_CNT_W-1:0]    ECALL_TIMEOUT     = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       id_ecall,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_jmp,
  input  logic       ex_branch_taken,
  input  logic       io_ack,
  output logic       stall,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       ecall_hold,
  output logic       io_req,
  output logic       io_timeout,
  output logic [2:0] state_dbg
);

  // The RUN cycle that detects the hazard is the first stall cycle, so the
  // counter covers only the remaining ones.
  localparam logic [3:0]             LU_RELOAD    = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [ECALL_CNT_W-1:0] TIMEOUT_LAST = ECALL_TIMEOUT - ECALL_CNT_W'(1);

  logic                   load_use;
  logic                   redirect;
  logic [STATE_W-1:0]     state_q, state_d;
  logic [3:0]             lu_cnt_q, lu_cnt_d;
  logic [ECALL_CNT_W-1:0] ecall_cnt_q, ecall_cnt_d;
  logic                   io_req_q, io_req_d;
  logic                   io_timeout_q, io_timeout_d;

  hazard_cmp u_hazard_cmp (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign redirect = ex_jmp | ex_branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      lu_cnt_q     <= '0;
      ecall_cnt_q  <= '0;
      io_req_q     <= 1'b0;
      io_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lu_cnt_q     <= lu_cnt_d;
      ecall_cnt_q  <= ecall_cnt_d;
      io_req_q     <= io_req_d;
      io_timeout_q <= io_timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lu_cnt_d     = lu_cnt_q;
    ecall_cnt_d  = ecall_cnt_q;
    io_req_d     = 1'b0;
    io_timeout_d = 1'b0;
    case (state_q)
      RUN: begin
        // A redirect squashes whatever sits in ID, so ecall/load-use are dropped.
        if (!redirect) begin
          if (id_ecall) begin
            state_d     = ECALL_REQ;
            ecall_cnt_d = '0;
            io_req_d    = 1'b1;
          end else if (load_use && (LOAD_STALL_CYCLES > 1)) begin
            state_d  = LU_STALL;
            lu_cnt_d = LU_RELOAD;
          end
        end
      end
      LU_STALL: begin
        lu_cnt_d = lu_cnt_q - 4'd1;
        if (lu_cnt_q <= 4'd1) begin
          state_d = RUN;
        end
      end
      ECALL_REQ: begin
        io_req_d = 1'b1;
        if (ecall_cnt_q != '1) begin
          ecall_cnt_d = ecall_cnt_q + ECALL_CNT_W'(1);
        end
        // Ack is checked first so a coincident timeout produces no pulse.
        if (io_req_q && io_ack) begin
          io_req_d = 1'b0;
          state_d  = ECALL_DONE;
        end else if ((ECALL_TIMEOUT != '0) && (ecall_cnt_q == TIMEOUT_LAST)) begin
          io_req_d     = 1'b0;
          io_timeout_d = 1'b1;
          state_d      = ECALL_DONE;
        end
      end
      ECALL_DONE: begin
        state_d = RUN;
      end
      default: begin
        state_d     = RUN;
        lu_cnt_d    = '0;
        ecall_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    ecall_hold  = 1'b0;
    case (state_q)
      RUN: begin
        if (redirect) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (id_ecall || load_use) begin
          stall       = 1'b1;
          flush_id_ex = 1'b1;
        end
      end
      LU_STALL: begin
        stall       = 1'b1;
        flush_id_ex = 1'b1;
      end
      ECALL_REQ: begin
        stall       = 1'b1;
        flush_id_ex = 1'b1;
        ecall_hold  = 1'b1;
      end
      ECALL_DONE: begin
        // The held ecall advances now; id_ecall is ignored to avoid re-trigger.
        if (redirect) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign io_req     = io_req_q;
  assign io_timeout = io_timeout_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, id_ecall, ex_mem_read;
  logic       ex_jmp, ex_branch_taken, io_ack;

  logic       a_stall, a_fif, a_fie, a_hold, a_req, a_to;
  logic [2:0] a_st;
  logic       b_stall, b_fif, b_fie, b_hold, b_req, b_to;
  logic [2:0] b_st;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // a: single-cycle load stall, short timeout. b: 3-cycle load stall, no timeout.
  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .ECALL_TIMEOUT(16'd8)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_ecall(id_ecall),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_jmp(ex_jmp),
    .ex_branch_taken(ex_branch_taken), .io_ack(io_ack),
    .stall(a_stall), .flush_if_id(a_fif), .flush_id_ex(a_fie),
    .ecall_hold(a_hold), .io_req(a_req), .io_timeout(a_to), .state_dbg(a_st)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .ECALL_TIMEOUT(16'd0)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_ecall(id_ecall),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_jmp(ex_jmp),
    .ex_branch_taken(ex_branch_taken), .io_ack(io_ack),
    .stall(b_stall), .flush_if_id(b_fif), .flush_id_ex(b_fie),
    .ecall_hold(b_hold), .io_req(b_req), .io_timeout(b_to), .state_dbg(b_st)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_ecall = 1'b0;
    ex_mem_read = 1'b0; ex_jmp = 1'b0; ex_branch_taken = 1'b0; io_ack = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #2;
    chk("rst_stall", {7'd0, a_stall}, 8'd0);
    chk("rst_fif",   {7'd0, a_fif},   8'd0);
    chk("rst_fie",   {7'd0, a_fie},   8'd0);
    chk("rst_hold",  {7'd0, a_hold},  8'd0);
    chk("rst_req",   {7'd0, a_req},   8'd0);
    chk("rst_to",    {7'd0, a_to},    8'd0);
    chk("rst_state", {5'd0, a_st},    8'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Load-use on rs1: a stalls once, b stalls three cycles (state 0,1,1,0).
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1;
    chk("lu_c0_a_stall", {7'd0, a_stall}, 8'd1);
    chk("lu_c0_a_fie",   {7'd0, a_fie},   8'd1);
    chk("lu_c0_a_fif",   {7'd0, a_fif},   8'd0);
    chk("lu_c0_b_stall", {7'd0, b_stall}, 8'd1);
    chk("lu_c0_b_state", {5'd0, b_st},    8'd0);
    cyc();
    idle_inputs();
    #1;
    chk("lu_c1_a_stall", {7'd0, a_stall}, 8'd0);
    chk("lu_c1_a_state", {5'd0, a_st},    8'd0);
    chk("lu_c1_b_stall", {7'd0, b_stall}, 8'd1);
    chk("lu_c1_b_state", {5'd0, b_st},    8'd1);
    cyc();
    chk("lu_c2_b_stall", {7'd0, b_stall}, 8'd1);
    chk("lu_c2_b_fie",   {7'd0, b_fie},   8'd1);
    chk("lu_c2_b_state", {5'd0, b_st},    8'd1);
    cyc();
    chk("lu_c3_b_stall", {7'd0, b_stall}, 8'd0);
    chk("lu_c3_b_state", {5'd0, b_st},    8'd0);

    // x0 destination never stalls; rs2 path and its enable are honoured.
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1;
    chk("x0_a_stall", {7'd0, a_stall}, 8'd0);
    chk("x0_b_stall", {7'd0, b_stall}, 8'd0);
    ex_rd = 5'd7; id_rs1 = 5'd0; id_uses_rs1 = 1'b0; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    #1;
    chk("rs2_a_stall", {7'd0, a_stall}, 8'd1);
    id_uses_rs2 = 1'b0;
    #1;
    chk("rs2_off_a_stall", {7'd0, a_stall}, 8'd0);
    ex_mem_read = 1'b0; id_uses_rs2 = 1'b1;
    #1;
    chk("noload_a_stall", {7'd0, a_stall}, 8'd0);
    idle_inputs();
    cyc();

    // Redirect beats coincident load-use and ecall.
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1; id_ecall = 1'b1;
    #1;
    chk("redir_fif",   {7'd0, a_fif},   8'd1);
    chk("redir_fie",   {7'd0, a_fie},   8'd1);
    chk("redir_stall", {7'd0, a_stall}, 8'd0);
    chk("redir_hold",  {7'd0, a_hold},  8'd0);
    cyc();
    idle_inputs();
    #1;
    chk("redir_a_state", {5'd0, a_st}, 8'd0);
    chk("redir_b_state", {5'd0, b_st}, 8'd0);
    chk("redir_a_req",   {7'd0, a_req}, 8'd0);
    ex_jmp = 1'b1;
    #1;
    chk("jmp_fif", {7'd0, a_fif}, 8'd1);
    idle_inputs();
    cyc();

    // Ecall handshake; io_ack while io_req=0 is ignored.
    id_ecall = 1'b1; io_ack = 1'b1;
    #1;
    chk("ec_c0_stall", {7'd0, a_stall}, 8'd1);
    chk("ec_c0_fie",   {7'd0, a_fie},   8'd1);
    chk("ec_c0_req",   {7'd0, a_req},   8'd0);
    chk("ec_c0_hold",  {7'd0, a_hold},  8'd0);
    cyc();
    io_ack = 1'b0;
    #1;
    chk("ec_c1_state", {5'd0, a_st},    8'd2);
    chk("ec_c1_req",   {7'd0, a_req},   8'd1);
    chk("ec_c1_hold",  {7'd0, a_hold},  8'd1);
    chk("ec_c1_stall", {7'd0, a_stall}, 8'd1);
    cyc();
    cyc();
    cyc();
    io_ack = 1'b1;
    #1;
    chk("ec_c4_state", {5'd0, a_st},  8'd2);
    chk("ec_c4_req",   {7'd0, a_req}, 8'd1);
    cyc();
    io_ack = 1'b0;
    #1;
    chk("ec_c5_req",   {7'd0, a_req},   8'd0);
    chk("ec_c5_state", {5'd0, a_st},    8'd3);
    chk("ec_c5_stall", {7'd0, a_stall}, 8'd0);
    chk("ec_c5_hold",  {7'd0, a_hold},  8'd0);
    chk("ec_c5_to",    {7'd0, a_to},    8'd0);
    chk("ec_c5_b_state", {5'd0, b_st},  8'd3);
    cyc();
    id_ecall = 1'b0;
    #1;
    chk("ec_c6_state", {5'd0, a_st},  8'd0);
    chk("ec_c6_req",   {7'd0, a_req}, 8'd0);
    cyc();
    chk("ec_c7_req",   {7'd0, a_req}, 8'd0);
    chk("ec_c7_state", {5'd0, a_st},  8'd0);

    // Timeout with no ack: pulse in cycle 9, eight cycles after entry.
    id_ecall = 1'b1;
    #1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("to_wait_pulse", {7'd0, a_to}, 8'd0);
      chk("to_wait_state", {5'd0, a_st}, 8'd2);
    end
    cyc();
    id_ecall = 1'b0;
    #1;
    chk("to_c9_pulse", {7'd0, a_to},  8'd1);
    chk("to_c9_state", {5'd0, a_st},  8'd3);
    chk("to_c9_req",   {7'd0, a_req}, 8'd0);
    chk("to_c9_b_state", {5'd0, b_st},  8'd2);
    chk("to_c9_b_req",   {7'd0, b_req}, 8'd1);
    cyc();
    chk("to_c10_pulse", {7'd0, a_to}, 8'd0);
    chk("to_c10_state", {5'd0, a_st}, 8'd0);

    // Async reset while b still requests: outputs fall before the next edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_b_req",   {7'd0, b_req},   8'd0);
    chk("arst_b_stall", {7'd0, b_stall}, 8'd0);
    chk("arst_b_hold",  {7'd0, b_hold},  8'd0);
    chk("arst_b_state", {5'd0, b_st},    8'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Ack in the timeout cycle wins: no pulse.
    id_ecall = 1'b1;
    #1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
    end
    cyc();
    io_ack = 1'b1;
    #1;
    chk("tack_c8_state", {5'd0, a_st}, 8'd2);
    cyc();
    io_ack = 1'b0; id_ecall = 1'b0;
    #1;
    chk("tack_c9_pulse", {7'd0, a_to},  8'd0);
    chk("tack_c9_state", {5'd0, a_st},  8'd3);
    chk("tack_c9_req",   {7'd0, a_req}, 8'd0);
    cyc();
    chk("tack_c10_pulse", {7'd0, a_to}, 8'd0);
    chk("tack_c10_state", {5'd0, a_st}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the MiniRiscV pipeline.
- Drives the fetch stage's stall input, the IF/ID and ID/EX flush controls, and the ecall hold into fetch.
- Resolves load-use hazards, control redirects from jumps and taken branches, and ecall I/O handshakes via a small FSM.
- Sits between the decode/execute stage outputs and the IF/ID/EX pipeline registers.

Parameters:
LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard (1..15)
ECALL_TIMEOUT, 16'd50000, cycles in ECALL_REQ before forced release (0 = wait forever)

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
id_rs1  in  5  source reg 1 of instruction in ID
id_rs2  in  5  source reg 2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_ecall  in  1  ID instruction is ecall
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  5  destination reg of EX instruction
ex_jmp  in  1  jal/jalr resolved in EX
ex_branch_taken  in  1  conditional branch taken in EX
io_ack  in  1  I/O device completed ecall service
stall  out  1  hold PC and IF/ID
flush_if_id  out  1  zero IF/ID (insert nop)
flush_id_ex  out  1  zero ID/EX (insert bubble)
ecall_hold  out  1  ecall in progress; fetch holds and emits nop
io_req  out  1  registered request to I/O device
io_timeout  out  1  registered one-cycle pulse on ecall timeout
state_dbg  out  3  current FSM state

Behaviour:
- Reset (async, active-high): state=RUN, counters=0, io_req=0, io_timeout=0. All combinational outputs evaluate to 0 in RUN with idle inputs.
- load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- redirect = ex_jmp | ex_branch_taken.
- Priority within one cycle: rst > redirect > id_ecall > load_use.
- RUN:
  - redirect: flush_if_id=1, flush_id_ex=1, stall=0; stay RUN. A coincident load_use or ecall is discarded.
  - else id_ecall: stall=1, flush_id_ex=1; next state ECALL_REQ; ecall_cnt<=0.
  - else load_use: stall=1, flush_id_ex=1. If LOAD_STALL_CYCLES>1, next state LU_STALL with lu_cnt<=LOAD_STALL_CYCLES-1; else stay RUN.
- LU_STALL:
  - stall=1, flush_id_ex=1, lu_cnt decrements each cycle.
  - When lu_cnt==1, next state RUN.
  - redirect is ignored here: EX holds a bubble by construction.
- ECALL_REQ:
  - stall=1, flush_id_ex=1, ecall_hold=1, io_req=1 (registered; asserts the cycle after entry).
  - io_ack is sampled only while io_req=1; io_ack with io_req=0 is ignored.
  - io_ack=1: io_req<=0, next state ECALL_DONE.
  - else if ECALL_TIMEOUT!=0 and ecall_cnt==ECALL_TIMEOUT-1: io_req<=0, io_timeout<=1 for one cycle, next state ECALL_DONE.
  - ecall_cnt is 16-bit and saturates; no wrap.
  - io_ack and timeout in the same cycle: ack wins, no io_timeout pulse.
- ECALL_DONE:
  - One cycle. stall=0, ecall_hold=0, so the ecall advances to EX.
  - id_ecall is ignored this cycle, preventing re-trigger by the same instruction.
  - redirect still flushes as in RUN.
  - Next state RUN.
- Reset mid-ECALL_REQ: io_req drops immediately (async), state RUN; the I/O device must tolerate an aborted request.
- ex_rd==0 never causes a load-use stall.
- state encoding: RUN=0, LU_STALL=1, ECALL_REQ=2, ECALL_DONE=3. State_dbg codes 4..7 are unused; an illegal state recovers to RUN next cycle with all outputs 0.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encodings RUN/LU_STALL/ECALL_REQ/ECALL_DONE
  - REG_X0=5'd0
  - ECALL_CNT_W=16
- One natural sub-module: hazard_cmp, purely combinational, computing load_use from the ID/EX register fields; reusable by a future forwarding unit.
- The FSM, counters and output decode stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1, LOAD_STALL_CYCLES=1 -> stall=1, flush_id_ex=1 for exactly 1 cycle; with ex_rd=0 -> no stall.
- LOAD_STALL_CYCLES=3, same hazard -> stall high exactly 3 consecutive cycles, state_dbg 0,1,1,0.
- Redirect vs hazard: ex_branch_taken=1 together with load_use=1 and id_ecall=1 -> flush_if_id=1, flush_id_ex=1, stall=0; state stays RUN.
- Ecall handshake: id_ecall=1 at cycle 0 -> io_req=1 from cycle 1; io_ack=1 at cycle 4 -> io_req=0 at cycle 5, ECALL_DONE with stall=0 at cycle 5 while id_ecall still high, RUN at cycle 6, no second io_req.
- Timeout: ECALL_TIMEOUT=8, io_ack never asserted -> io_timeout one-cycle pulse 8 cycles after ECALL_REQ entry, then ECALL_DONE, RUN; io_ack in the timeout cycle -> no pulse.
- Async reset while io_req=1 -> io_req, stall and ecall_hold fall before the next clk edge; state_dbg=0.
